adder_accum_ctrl: RTL
=====================

ADDER_ACCUM_CTRL -- requirements
Module: adder_accum_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, 6, operand/accumulator width matching the ripple adder datapath.
REQ-002 SHALL have parameter SETTLE_CYCLES, 2, cycles the adder inputs are held before the sum is captured (minimum 1).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  clear accumulator and begin a sequence; honoured only in IDLE.
REQ-006 op_valid  in  1  operand offered.
REQ-007 op_ready  out  1  operand accepted when op_valid and op_ready are both high at a rising edge.
REQ-008 op_data  in  WIDTH  operand.
REQ-009 op_sub  in  1  1 = subtract operand, 0 = add.
REQ-010 op_last  in  1  marks final operand of the sequence.
REQ-011 add_x / add_y  out  WIDTH  adder operands; add_cin  out  1  adder carry-in.
REQ-012 add_sum  in  WIDTH; add_cout  in  1; add_ovf  in  1; combinational adder results.
REQ-013 acc  out  WIDTH; acc_cout  out  1 (last captured carry); acc_ovf  out  1 (sticky overflow).
REQ-014 op_count  out  4  accepted operands, saturating; busy  out  1; done  out  1.

Function
REQ-015 SHALL implement FSM IDLE -> ACCEPT -> SETTLE -> (ACCEPT | DONE) -> IDLE.
REQ-016 IDLE: start=1 -> acc, acc_cout, acc_ovf, op_count cleared to 0; next state ACCEPT.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 ACCEPT: op_ready=1 only here; on handshake, latch add_y = op_sub ? ~op_data : op_data and add_cin = op_sub; latch op_last; op_count += 1, saturating at 15; next state SETTLE.
REQ-019 add_x SHALL equal acc at all times.
REQ-020 SETTLE: hold add_y and add_cin for exactly SETTLE_CYCLES cycles; on the final SETTLE edge, capture acc <= add_sum, acc_cout <= add_cout, acc_ovf <= acc_ovf | add_ovf.
REQ-021 Capture-edge latency: handshake at edge k -> acc updated at edge k+SETTLE_CYCLES.
REQ-022 After capture: latched op_last=1 -> DONE; otherwise -> ACCEPT.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; acc and flags hold until the next start.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH; the carry out of the MSB is reported only via acc_cout.
REQ-026 op_valid with op_ready=0 SHALL have no effect; op_data, op_sub and op_last are ignored outside the ACCEPT handshake.

Reset
REQ-027 rst_n=0 SHALL immediately force the IDLE state, with acc, add_y, add_cin, acc_cout, acc_ovf, op_count, op_ready, busy and done all set to 0, regardless of current state (including mid-SETTLE).
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start is asserted.

Verification
REQ-029 Assert reset, then release it -> all outputs 0, op_ready=0, busy=0.
REQ-030 Apply start, then add 2, then add 1 with op_last -> acc=3, acc_cout=0, acc_ovf=0, op_count=2; done high for 1 cycle; busy=0 afterwards.
REQ-031 Apply start, add 16 (010000), then add 16 -> acc=32 (100000), acc_ovf=1; add 0 with op_last -> acc_ovf still 1.
REQ-032 Apply start, add 48 (110000), then add 24 (011000) with op_last -> acc=8 (001000), acc_cout=1, acc_ovf=0.
REQ-033 Apply start, add 5, then subtract 3 with op_last -> add_y=111100, add_cin=1, acc=2, acc_cout=1; a start pulsed during SETTLE is ignored.
REQ-034 Apply 17 operands without op_last -> op_count saturates at 15; then pulse rst_n low during SETTLE -> all state returns to 0 asynchronously and the FSM is in IDLE.

Source files
------------

// File: rtl/adder_accum_ctrl.sv
// -----------------------------------------------------------------------------
// adder_accum_ctrl
//
// Purpose: sequences an external combinational ripple adder to accumulate a
// stream of signed/unsigned operands. Each accepted operand is applied to the
// adder (add_y/add_cin, with subtraction as ~op + 1) and held for
// SETTLE_CYCLES cycles. The sum is then captured into the accumulator. add_x
// always mirrors the accumulator.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  clear accumulator and begin a sequence (IDLE only)
//   op_valid/op_ready      operand handshake
//   op_data/op_sub/op_last operand, subtract select, end-of-sequence marker
//   add_x/add_y/add_cin    operands driven to the external adder
//   add_sum/add_cout/add_ovf  combinational results from the external adder
//   acc/acc_cout/acc_ovf   accumulator, last carry, sticky overflow
//   op_count               accepted operands (saturates at 15)
//   busy/done              not-IDLE indicator, one-cycle completion pulse
// -----------------------------------------------------------------------------
module adder_accum_ctrl #(
    parameter int WIDTH         = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_sub,
    input  logic             op_last,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    input  logic             add_ovf,
    output logic [WIDTH-1:0] acc,
    output logic             acc_cout,
    output logic             acc_ovf,
    output logic [3:0]       op_count,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int              CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q,      state_d;
    logic [WIDTH-1:0] acc_q,        acc_d;
    logic             acc_cout_q,   acc_cout_d;
    logic             acc_ovf_q,    acc_ovf_d;
    logic [WIDTH-1:0] add_y_q,      add_y_d;
    logic             add_cin_q,    add_cin_d;
    logic             last_q,       last_d;
    logic [3:0]       op_count_q,   op_count_d;
    logic [CW-1:0]    settle_cnt_q, settle_cnt_d;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_cout_d   = acc_cout_q;
        acc_ovf_d    = acc_ovf_q;
        add_y_d      = add_y_q;
        add_cin_d    = add_cin_q;
        last_d       = last_q;
        op_count_d   = op_count_q;
        settle_cnt_d = settle_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d      = '0;
                    acc_cout_d = 1'b0;
                    acc_ovf_d  = 1'b0;
                    op_count_d = 4'd0;
                    state_d    = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (op_valid) begin
                    // Subtraction as two's complement: invert here, +1 via carry-in.
                    add_y_d      = op_sub ? ~op_data : op_data;
                    add_cin_d    = op_sub;
                    last_d       = op_last;
                    op_count_d   = (op_count_q == 4'd15) ? 4'd15 : op_count_q + 4'd1;
                    // Count down from SETTLE_CYCLES-1; capture when it reaches 0.
                    settle_cnt_d = SETTLE_LAST;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    acc_d      = add_sum;
                    acc_cout_d = add_cout;
                    acc_ovf_d  = acc_ovf_q | add_ovf;
                    state_d    = last_q ? S_DONE : S_ACCEPT;
                end else begin
                    settle_cnt_d = settle_cnt_q - CW'(1);
                end
            end
            default: begin  // S_DONE: single-cycle pulse
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            acc_cout_q   <= 1'b0;
            acc_ovf_q    <= 1'b0;
            add_y_q      <= '0;
            add_cin_q    <= 1'b0;
            last_q       <= 1'b0;
            op_count_q   <= 4'd0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cout_q   <= acc_cout_d;
            acc_ovf_q    <= acc_ovf_d;
            add_y_q      <= add_y_d;
            add_cin_q    <= add_cin_d;
            last_q       <= last_d;
            op_count_q   <= op_count_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign add_x    = acc_q;
    assign add_y    = add_y_q;
    assign add_cin  = add_cin_q;
    assign acc      = acc_q;
    assign acc_cout = acc_cout_q;
    assign acc_ovf  = acc_ovf_q;
    assign op_count = op_count_q;
    assign op_ready = (state_q == S_ACCEPT);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule
